// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/branch controller for the 8-bit program counter.
// Steers the PC via branch_enable/branch_target to stall (reload own value), jump,
// conditionally branch, call/return and halt. Sequence: IDLE -> FETCH -> EXEC -> FETCH|HALT.
// Build option: define SEQ_RAS_EN to include a RAS_DEPTH-entry return-address stack;
// without it op_call behaves as op_jump and op_ret is a flagged no-op.
module pc_sequencer #(
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         pc_value,
  output logic                               imem_req,
  input  logic                               imem_ack,
  input  logic                               op_jump,
  input  logic                               op_branch_z,
  input  logic                               op_call,
  input  logic                               op_ret,
  input  logic                               op_halt,
  input  logic [7:0]                         target,
  input  logic                               flag_z,
  input  logic                               resume,
  output logic                               branch_enable,
  output logic [7:0]                         branch_target,
  output logic                               exec_valid,
  output logic                               halted,
  output logic                               stack_err,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_level
);

  localparam int unsigned LvlW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

  state_e state_q;
  logic   stack_err_q;
  logic   in_exec;
  logic   sel_ret, sel_call;
  logic   ret_ok;
  logic   err_set;
  logic [7:0] ras_top;

  assign in_exec = (state_q == StExec);
  // Priority halt > ret > call; only ret/call touch the stack.
  assign sel_ret  = !op_halt && op_ret;
  assign sel_call = !op_halt && !op_ret && op_call;

`ifdef SEQ_RAS_EN
  localparam int unsigned IdxW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [7:0]      ras_q [RAS_DEPTH];
  logic [LvlW-1:0] ras_level_q;
  logic            ras_empty, ras_full;
  logic            do_push, do_pop;
  logic [7:0]      pc_inc;
  logic [IdxW-1:0] push_idx, top_idx;

  assign ras_empty = (ras_level_q == '0);
  assign ras_full  = (ras_level_q == LvlW'(RAS_DEPTH));
  assign pc_inc    = pc_value + 8'd1;
  assign push_idx  = IdxW'(ras_level_q);
  assign top_idx   = IdxW'(ras_level_q - LvlW'(1));
  assign ras_top   = ras_q[top_idx];
  assign ret_ok    = !ras_empty;
  assign do_push   = in_exec && sel_call && !ras_full;
  assign do_pop    = in_exec && sel_ret && !ras_empty;
  // Full-stack call still jumps (output logic) but loses its return address.
  assign err_set   = in_exec && ((sel_ret && ras_empty) || (sel_call && ras_full));
  assign ras_level = ras_level_q;

  // Return-address stack storage and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ras_level_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= 8'h00;
    end else if (do_push) begin
      ras_q[push_idx] <= pc_inc;
      ras_level_q     <= ras_level_q + LvlW'(1);
    end else if (do_pop) begin
      ras_level_q <= ras_level_q - LvlW'(1);
    end
  end
`else
  // No stack: every ret is an error and falls through as an increment.
  assign ret_ok    = 1'b0;
  assign ras_top   = 8'h00;
  assign err_set   = in_exec && sel_ret;
  assign ras_level = '0;
`endif

  // Sticky stack error, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stack_err_q <= 1'b0;
    end else if (err_set) begin
      stack_err_q <= 1'b1;
    end
  end

  assign stack_err = stack_err_q;

  // Sequencing state machine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_q <= StFetch;
        StFetch: if (imem_ack) state_q <= StExec;
        StExec:  state_q <= op_halt ? StHalt : StFetch;
        StHalt:  if (resume) state_q <= StFetch;
        default: state_q <= StIdle;
      endcase
    end
  end

  // PC steering and status outputs; default is a stall (reload own value).
  always_comb begin
    imem_req      = 1'b0;
    exec_valid    = 1'b0;
    halted        = 1'b0;
    branch_enable = 1'b1;
    branch_target = pc_value;
    unique case (state_q)
      StIdle: ;
      StFetch: imem_req = 1'b1;
      StExec: begin
        exec_valid = 1'b1;
        if (op_halt) begin
          branch_enable = 1'b1;
        end else if (op_ret) begin
          if (ret_ok) branch_target = ras_top;
          else        branch_enable = 1'b0;
        end else if (op_call || op_jump) begin
          branch_target = target;
        end else if (op_branch_z && flag_z) begin
          branch_target = target;
        end else begin
          branch_enable = 1'b0;
        end
      end
      StHalt: begin
        halted = 1'b1;
        if (resume) branch_enable = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer; includes a simple PC register model.
// Expected values depend on whether SEQ_RAS_EN is defined for the build.
module tb_pc_sequencer;

  localparam int unsigned RAS_DEPTH = 4;
  localparam int unsigned LVLW = $clog2(RAS_DEPTH + 1);
`ifdef SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic            clk, rst;
  logic [7:0]      pc_value;
  logic            imem_req, imem_ack;
  logic            op_jump, op_branch_z, op_call, op_ret, op_halt;
  logic [7:0]      target;
  logic            flag_z, resume;
  logic            branch_enable;
  logic [7:0]      branch_target;
  logic            exec_valid, halted, stack_err;
  logic [LVLW-1:0] ras_level;

  int total = 0;
  int bad = 0;

  pc_sequencer #(.RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_value(pc_value), .imem_req(imem_req), .imem_ack(imem_ack),
    .op_jump(op_jump), .op_branch_z(op_branch_z), .op_call(op_call), .op_ret(op_ret),
    .op_halt(op_halt), .target(target), .flag_z(flag_z), .resume(resume),
    .branch_enable(branch_enable), .branch_target(branch_target), .exec_valid(exec_valid),
    .halted(halted), .stack_err(stack_err), .ras_level(ras_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register driven by the sequencer.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_value <= 8'h00;
    else      pc_value <= branch_enable ? branch_target : pc_value + 8'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    op_jump = 0; op_branch_z = 0; op_call = 0; op_ret = 0; op_halt = 0; flag_z = 0;
  endtask

  // From FETCH: ack at once, present the op in EXEC, return in the next state.
  task automatic run_instr(input logic j, input logic bz, input logic c, input logic r,
                           input logic [7:0] tgt, input logic z);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    op_jump = j; op_branch_z = bz; op_call = c; op_ret = r; target = tgt; flag_z = z;
    #1;
    check("exec_valid", exec_valid, 1);
    tick();
    clear_ops();
  endtask

  logic [7:0] ret_exp [4];

  initial begin
    rst = 1'b0; imem_ack = 1'b0; target = 8'h00; resume = 1'b0;
    clear_ops();
    // Reset values
    tick();
    check("rst_imem_req", imem_req, 0);
    check("rst_branch_en", branch_enable, 1);
    check("rst_branch_tgt", branch_target, 8'h00);
    check("rst_exec_valid", exec_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_ras_level", ras_level, 0);
    check("rst_stack_err", stack_err, 0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("idle_imem_req", imem_req, 0);
    tick();

    // Test 1: three wait cycles then ack; resume ignored in FETCH
    resume = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t1_fetch_req", imem_req, 1);
      check("t1_fetch_hold", branch_enable, 1);
      tick();
    end
    resume = 1'b0;
    imem_ack = 1'b1;
    #1;
    check("t1_ack_req", imem_req, 1);
    check("t1_ack_hold", branch_enable, 1);
    tick();
    imem_ack = 1'b0;
    #1;
    check("t1_exec_valid", exec_valid, 1);
    check("t1_exec_req", imem_req, 0);
    check("t1_exec_pc", pc_value, 8'h00);
    tick();
    check("t1_pc", pc_value, 8'h01);
    check("t1_back_fetch", imem_req, 1);

    // Test 2: branch_z taken / not taken; jump beats branch_z
    run_instr(0, 1, 0, 0, 8'h40, 1);
    check("t2_bz_taken", pc_value, 8'h40);
    run_instr(0, 1, 0, 0, 8'h40, 0);
    check("t2_bz_not", pc_value, 8'h41);
    run_instr(1, 1, 0, 0, 8'h10, 0);
    check("t2_jump", pc_value, 8'h10);

    // Test 3: call then ret
    run_instr(0, 0, 1, 0, 8'h80, 0);
    check("t3_call_pc", pc_value, 8'h80);
    check("t3_call_lvl", ras_level, RAS ? 1 : 0);
    check("t3_call_err", stack_err, 0);
    run_instr(0, 0, 0, 1, 8'h99, 0);
    check("t3_ret_pc", pc_value, RAS ? 8'h11 : 8'h81);
    check("t3_ret_lvl", ras_level, 0);
    check("t3_ret_err", stack_err, RAS ? 1'b0 : 1'b1);

`ifdef SEQ_RAS_EN
    // Test 4: overflow on fifth nested call, then unwind
    for (int i = 0; i < 5; i++) begin
      run_instr(0, 0, 1, 0, 8'h50 + 8'(i), 0);
      check("t4_call_pc", pc_value, 8'h50 + 8'(i));
      check("t4_call_lvl", ras_level, (i < 4) ? i + 1 : 4);
      check("t4_call_err", stack_err, (i < 4) ? 0 : 1);
    end
    ret_exp[0] = 8'h53; ret_exp[1] = 8'h52; ret_exp[2] = 8'h51; ret_exp[3] = 8'h12;
    for (int i = 0; i < 4; i++) begin
      run_instr(0, 0, 0, 1, 8'hEE, 0);
      check("t4_ret_pc", pc_value, ret_exp[i]);
      check("t4_ret_lvl", ras_level, 3 - i);
    end
`endif

    // Test 5: halt (with jump/ret also asserted) holds PC; resume steps past it
    run_instr(1, 0, 0, 0, 8'h20, 0);
    check("t5_jump_pc", pc_value, 8'h20);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    op_halt = 1'b1; op_jump = 1'b1; op_ret = 1'b1; target = 8'h77;
    #1;
    check("t5_exec_be", branch_enable, 1);
    check("t5_exec_tgt", branch_target, 8'h20);
    tick();
    op_halt = 1'b0; op_ret = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t5_halted", halted, 1);
      check("t5_hold_pc", pc_value, 8'h20);
      check("t5_hold_be", branch_enable, 1);
      tick();
    end
    check("t5_halt_lvl", ras_level, 0);
    op_jump = 1'b0;
    resume = 1'b1;
    #1;
    check("t5_resume_be", branch_enable, 0);
    tick();
    resume = 1'b0;
    check("t5_resume_pc", pc_value, 8'h21);
    check("t5_resume_req", imem_req, 1);
    check("t5_resume_halted", halted, 0);

    // Test 6: async reset mid-FETCH with two return addresses stacked
    run_instr(0, 0, 1, 0, 8'h30, 0);
    run_instr(0, 0, 1, 0, 8'h31, 0);
    check("t6_pc", pc_value, 8'h31);
    check("t6_lvl", ras_level, RAS ? 2 : 0);
    check("t6_err_pre", stack_err, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_req", imem_req, 0);
    check("t6_rst_lvl", ras_level, 0);
    check("t6_rst_err", stack_err, 0);
    check("t6_rst_be", branch_enable, 1);
    check("t6_rst_exec", exec_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("t6_fetch_req", imem_req, 1);
    // Ret on empty stack after reset: increment and flag
    run_instr(0, 0, 0, 1, 8'h55, 0);
    check("t6_ret_empty_pc", pc_value, 8'h01);
    check("t6_ret_empty_err", stack_err, 1);
    check("t6_ret_empty_lvl", ras_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
